// File: rtl/fft_disp_pkg.sv
// Shared definitions for the FFT-modulus display path: FIFO word field
// positions and the frame reader state encoding.
package fft_disp_pkg;

  localparam int SOF_BIT = 72;
  localparam int IDX_MSB = 43;
  localparam int IDX_LSB = 32;
  localparam int MAG_MSB = 31;
  localparam int MAG_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/fft_mag_scale_sat.sv
// Combinational right-shift of a modulus followed by saturation to the
// display sample range.
module fft_mag_scale_sat #(
  parameter int MAG_W  = 32,
  parameter int DISP_W = 10
) (
  input  logic [MAG_W-1:0]  mag,
  input  logic [4:0]        shift,
  output logic [DISP_W-1:0] disp
);

  localparam logic [MAG_W-1:0] DISP_MAX = {{(MAG_W-DISP_W){1'b0}}, {DISP_W{1'b1}}};

  logic [MAG_W-1:0] shifted_s;

  // shift first, then clamp to the largest displayable sample
  always_comb begin
    shifted_s = '0;
    disp      = '0;
    if ({27'd0, shift} >= 32'(MAG_W)) begin
      shifted_s = '0;
    end else begin
      shifted_s = mag >> shift;
    end
    if (shifted_s > DISP_MAX) begin
      disp = {DISP_W{1'b1}};
    end else begin
      disp = shifted_s[DISP_W-1:0];
    end
  end

endmodule

// File: rtl/fft_modulus_frame_reader.sv
// Drains the FFT-modulus prefetch FIFO, aligns to start-of-frame and writes one
// frame of scaled magnitudes into the display RAM while tracking the peak bin.
module fft_modulus_frame_reader
  import fft_disp_pkg::*;
#(
  parameter int DATA_W    = 73,
  parameter int MAG_W     = 32,
  parameter int IDX_W     = 12,
  parameter int POINTS    = 4096,
  parameter int DISP_W    = 10,
  parameter int PEAK_SKIP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_rd_vld,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  input  logic              frame_req,
  input  logic [4:0]        scale_shift,
  output logic              ram_wr_en,
  output logic [IDX_W-1:0]  ram_wr_addr,
  output logic [DISP_W-1:0] ram_wr_data,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [MAG_W-1:0]  peak_mag,
  output logic [IDX_W-1:0]  peak_idx
);

  localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(POINTS - 1);
  localparam logic [IDX_W:0] SKIP_CNT = (IDX_W+1)'(PEAK_SKIP);

  state_e              state_r, state_nxt_s;
  logic [IDX_W:0]      cnt_r;
  logic [4:0]          shift_r;
  logic [MAG_W-1:0]    run_max_r, nxt_max_s;
  logic [IDX_W-1:0]    run_idx_r, nxt_idx_s;
  logic                ram_wr_en_r, frame_err_r;
  logic [IDX_W-1:0]    ram_wr_addr_r, peak_idx_r;
  logic [DISP_W-1:0]   ram_wr_data_r, disp_s;
  logic [MAG_W-1:0]    peak_mag_r, mag_s;
  logic                sof_s, in_frame_s, bin0_s, mid_sof_s, read_bin_s, last_s;
  logic                unused_fields_s;

  assign sof_s           = fifo_rd_data[SOF_BIT];
  assign mag_s           = fifo_rd_data[MAG_MSB:MAG_LSB];
  assign unused_fields_s = ^fifo_rd_data[SOF_BIT-1:MAG_MSB+1];

  assign in_frame_s = (state_r == ST_SYNC) || (state_r == ST_READ);
  assign fifo_rd_en = fifo_rd_vld & in_frame_s;

  // bin 0 is either the aligning sof in SYNC or a sof that truncates a frame
  assign mid_sof_s  = fifo_rd_en && (state_r == ST_READ) && sof_s && (cnt_r != '0);
  assign bin0_s     = fifo_rd_en && sof_s;
  assign read_bin_s = fifo_rd_en && (state_r == ST_READ) && !sof_s;
  assign last_s     = read_bin_s && (cnt_r == LAST_CNT);

  fft_mag_scale_sat #(.MAG_W(MAG_W), .DISP_W(DISP_W)) u_scale (
    .mag   (mag_s),
    .shift (shift_r),
    .disp  (disp_s)
  );

  // next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_req) state_nxt_s = ST_SYNC;
        else           state_nxt_s = ST_IDLE;
      end
      ST_SYNC: begin
        if (bin0_s) state_nxt_s = ST_READ;
        else        state_nxt_s = ST_SYNC;
      end
      ST_READ: begin
        if (last_s) state_nxt_s = ST_DONE;
        else        state_nxt_s = ST_READ;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // running peak including the bin being consumed this cycle
  always_comb begin
    nxt_max_s = run_max_r;
    nxt_idx_s = run_idx_r;
    if (bin0_s) begin
      nxt_max_s = '0;
      nxt_idx_s = '0;
    end else if (read_bin_s && (cnt_r >= SKIP_CNT) && (mag_s > run_max_r)) begin
      nxt_max_s = mag_s;
      nxt_idx_s = cnt_r[IDX_W-1:0];
    end else begin
      nxt_max_s = run_max_r;
      nxt_idx_s = run_idx_r;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // bin counter, RAM write port, peak tracker and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r         <= '0;
      shift_r       <= '0;
      run_max_r     <= '0;
      run_idx_r     <= '0;
      ram_wr_en_r   <= 1'b0;
      ram_wr_addr_r <= '0;
      ram_wr_data_r <= '0;
      frame_err_r   <= 1'b0;
      peak_mag_r    <= '0;
      peak_idx_r    <= '0;
    end else begin
      ram_wr_en_r <= 1'b0;
      frame_err_r <= mid_sof_s;
      run_max_r   <= nxt_max_s;
      run_idx_r   <= nxt_idx_s;
      if (state_r == ST_IDLE && frame_req) shift_r <= scale_shift;
      if (bin0_s) begin
        cnt_r         <= (IDX_W+1)'(1);
        ram_wr_en_r   <= 1'b1;
        ram_wr_addr_r <= '0;
        ram_wr_data_r <= disp_s;
      end else if (read_bin_s) begin
        cnt_r         <= cnt_r + (IDX_W+1)'(1);
        ram_wr_en_r   <= 1'b1;
        ram_wr_addr_r <= cnt_r[IDX_W-1:0];
        ram_wr_data_r <= disp_s;
      end else if (state_r == ST_DONE) begin
        cnt_r <= '0;
      end
      if (last_s) begin
        peak_mag_r <= nxt_max_s;
        peak_idx_r <= nxt_idx_s;
      end
    end
  end

  assign ram_wr_en   = ram_wr_en_r;
  assign ram_wr_addr = ram_wr_addr_r;
  assign ram_wr_data = ram_wr_data_r;
  assign frame_err   = frame_err_r;
  assign peak_mag    = peak_mag_r;
  assign peak_idx    = peak_idx_r;
  assign frame_busy  = (state_r != ST_IDLE);
  assign frame_done  = (state_r == ST_DONE);

endmodule

// File: tb/tb_fft_modulus_frame_reader.sv
// Directed bench for fft_modulus_frame_reader with POINTS=16: a queue models
// the prefetch FIFO and RAM writes are logged per frame.
module tb_fft_modulus_frame_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fifo_rd_vld = 1'b0;
  logic [72:0] fifo_rd_data = '0;
  logic        fifo_rd_en;
  logic        frame_req = 1'b0;
  logic [4:0]  scale_shift = 5'd0;
  logic        ram_wr_en;
  logic [11:0] ram_wr_addr;
  logic [9:0]  ram_wr_data;
  logic        frame_busy, frame_done, frame_err;
  logic [31:0] peak_mag;
  logic [11:0] peak_idx;

  int checks = 0;
  int errors = 0;

  logic [72:0] q[$];
  int          addr_log[$];
  logic [9:0]  data_log[$];
  logic [9:0]  mem[16];
  int          done_cnt, err_cnt, err_addr, bad_pop;
  bit          gate_rand = 1'b0;
  logic [31:0] pk_mag;
  logic [11:0] pk_idx;

  always #5 clk = ~clk;

  fft_modulus_frame_reader #(.POINTS(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_rd_vld  (fifo_rd_vld),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .frame_req    (frame_req),
    .scale_shift  (scale_shift),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wr_data  (ram_wr_data),
    .frame_busy   (frame_busy),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .peak_mag     (peak_mag),
    .peak_idx     (peak_idx)
  );

  function automatic logic [72:0] mk(input logic sof, input logic [31:0] mag);
    return {sof, 28'd0, 12'hABC, mag};
  endfunction

  // one clock: log last edge's outputs, present the FIFO head, pop if taken
  task automatic step();
    @(negedge clk);
    if (ram_wr_en) begin
      addr_log.push_back(int'(ram_wr_addr));
      data_log.push_back(ram_wr_data);
      mem[ram_wr_addr[3:0]] = ram_wr_data;
    end
    if (frame_err) begin
      err_cnt++;
      err_addr = ram_wr_en ? int'(ram_wr_addr) : -1;
    end
    if (frame_done) begin
      done_cnt++;
      pk_mag = peak_mag;
      pk_idx = peak_idx;
    end
    fifo_rd_vld  = (q.size() > 0) && (!gate_rand || ($urandom_range(0, 1) == 1));
    fifo_rd_data = (q.size() > 0) ? q[0] : '0;
    #1;
    if (fifo_rd_en) begin
      if (!fifo_rd_vld) bad_pop++;
      else void'(q.pop_front());
    end
  endtask

  task automatic run_frame(input int budget, input logic [4:0] shift, output bit ok);
    addr_log.delete();
    data_log.delete();
    done_cnt = 0; err_cnt = 0; err_addr = -1; bad_pop = 0;
    ok = 1'b0;
    scale_shift = shift;
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    scale_shift = ~shift;
    for (int c = 0; c < budget; c++) begin
      step();
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    step();
  endtask

  task automatic push_ramp(input logic [31:0] m0, input logic [31:0] m1);
    for (int k = 0; k < 16; k++) begin
      if (k == 0)      q.push_back(mk(1'b1, m0));
      else if (k == 1) q.push_back(mk(1'b0, m1));
      else             q.push_back(mk(1'b0, 32'(k * 100)));
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({fifo_rd_en, ram_wr_en, ram_wr_addr, ram_wr_data, frame_busy, frame_done,
         frame_err, peak_mag, peak_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b we=%b a=%0d d=%0d busy=%b done=%b err=%b pm=%0d pi=%0d exp all 0",
               fifo_rd_en, ram_wr_en, ram_wr_addr, ram_wr_data, frame_busy, frame_done,
               frame_err, peak_mag, peak_idx);
    end
    step();
    rst_n = 1'b1;
    q.push_back(mk(1'b1, 32'd7));
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (q.size() != 1 || frame_busy !== 1'b0 || addr_log.size() != 0) begin
      errors++;
      $display("FAIL idle_no_pop got qsize=%0d busy=%b writes=%0d exp 1 0 0",
               q.size(), frame_busy, addr_log.size());
    end
    q.delete();
  endtask

  task automatic check_ramp_frame(input string tag, input bit ok);
    logic [9:0] exp_d;
    checks++;
    if (!ok || done_cnt != 1) begin
      errors++;
      $display("FAIL %s_done got ok=%0d done_cnt=%0d exp 1 1", tag, ok, done_cnt);
    end
    checks++;
    if (addr_log.size() != 16) begin
      errors++;
      $display("FAIL %s_nwrites got %0d exp 16", tag, addr_log.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        exp_d = (i * 100 > 1023) ? 10'd1023 : 10'(i * 100);
        checks++;
        if (addr_log[i] != i || data_log[i] !== exp_d) begin
          errors++;
          $display("FAIL %s_write[%0d] got a=%0d d=%0d exp a=%0d d=%0d",
                   tag, i, addr_log[i], data_log[i], i, exp_d);
        end
      end
    end
    checks++;
    if (pk_mag !== 32'd1500 || pk_idx !== 12'd15 || frame_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_peak got mag=%0d idx=%0d busy=%b exp 1500 15 0", tag, pk_mag, pk_idx, frame_busy);
    end
  endtask

  task automatic test_basic();
    bit ok;
    push_ramp(32'd0, 32'd100);
    run_frame(60, 5'd0, ok);
    check_ramp_frame("basic", ok);
  endtask

  task automatic test_junk();
    bit ok;
    for (int i = 0; i < 3; i++) q.push_back(mk(1'b0, 32'hFFFF_FFFF));
    push_ramp(32'd0, 32'd100);
    run_frame(60, 5'd0, ok);
    check_ramp_frame("junk", ok);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL junk_drained got qsize=%0d exp 0", q.size());
    end
  endtask

  task automatic test_scale();
    bit ok;
    logic [9:0] exp_d[4];
    exp_d[0] = 10'h123; exp_d[1] = 10'd1023; exp_d[2] = 10'd1023; exp_d[3] = 10'd1;
    q.push_back(mk(1'b1, 32'h0000_1230));
    q.push_back(mk(1'b0, 32'h0000_3FF0));
    q.push_back(mk(1'b0, 32'hFFFF_FFFF));
    for (int k = 3; k < 16; k++) q.push_back(mk(1'b0, 32'h10));
    run_frame(60, 5'd4, ok);
    checks++;
    if (!ok || addr_log.size() != 16) begin
      errors++;
      $display("FAIL scale_frame got ok=%0d writes=%0d exp 1 16", ok, addr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (data_log[i] !== exp_d[i]) begin
          errors++;
          $display("FAIL scale_data[%0d] got %0h exp %0h", i, data_log[i], exp_d[i]);
        end
      end
    end
    checks++;
    if (pk_mag !== 32'hFFFF_FFFF || pk_idx !== 12'd2) begin
      errors++;
      $display("FAIL scale_peak got mag=%0h idx=%0d exp ffffffff 2", pk_mag, pk_idx);
    end
  endtask

  task automatic test_sof_mid();
    bit ok;
    for (int k = 0; k < 7; k++) q.push_back(mk(k == 0, 32'd5000));
    for (int k = 0; k < 16; k++) q.push_back(mk(k == 0, 32'(k * 10)));
    run_frame(80, 5'd0, ok);
    checks++;
    if (!ok || done_cnt != 1 || err_cnt != 1 || err_addr != 0) begin
      errors++;
      $display("FAIL sofmid_pulses got ok=%0d done=%0d err=%0d err_addr=%0d exp 1 1 1 0",
               ok, done_cnt, err_cnt, err_addr);
    end
    checks++;
    if (addr_log.size() != 23) begin
      errors++;
      $display("FAIL sofmid_nwrites got %0d exp 23", addr_log.size());
    end else begin
      for (int i = 0; i < 23; i++) begin
        checks++;
        if (addr_log[i] != ((i < 7) ? i : i - 7)) begin
          errors++;
          $display("FAIL sofmid_addr[%0d] got %0d exp %0d", i, addr_log[i], (i < 7) ? i : i - 7);
        end
      end
    end
    checks++;
    if (pk_mag !== 32'd150 || pk_idx !== 12'd15) begin
      errors++;
      $display("FAIL sofmid_peak got mag=%0d idx=%0d exp 150 15", pk_mag, pk_idx);
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [9:0] exp_d;
    for (int i = 0; i < 16; i++) mem[i] = 10'h3AA;
    gate_rand = 1'b1;
    push_ramp(32'd0, 32'd100);
    run_frame(400, 5'd0, ok);
    gate_rand = 1'b0;
    check_ramp_frame("stall", ok);
    for (int i = 0; i < 16; i++) begin
      exp_d = (i * 100 > 1023) ? 10'd1023 : 10'(i * 100);
      checks++;
      if (mem[i] !== exp_d) begin
        errors++;
        $display("FAIL stall_mem[%0d] got %0d exp %0d", i, mem[i], exp_d);
      end
    end
    checks++;
    if (bad_pop != 0) begin
      errors++;
      $display("FAIL stall_pop_without_vld got %0d exp 0", bad_pop);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    addr_log.delete();
    data_log.delete();
    push_ramp(32'd0, 32'd100);
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    for (int c = 0; c < 60 && addr_log.size() < 9; c++) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (addr_log.size() != 9 || {fifo_rd_en, ram_wr_en, ram_wr_addr, ram_wr_data, frame_busy,
         frame_done, frame_err, peak_mag, peak_idx} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got writes=%0d en=%b we=%b a=%0d d=%0d busy=%b exp 9 then all 0",
               addr_log.size(), fifo_rd_en, ram_wr_en, ram_wr_addr, ram_wr_data, frame_busy);
    end
    step();
    q.delete();
    rst_n = 1'b1;
    push_ramp(32'hFFFF_FFFF, 32'hFFFF_FFFE);
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (q.size() != 16 || frame_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle got qsize=%0d busy=%b exp 16 0", q.size(), frame_busy);
    end
    run_frame(60, 5'd0, ok);
    checks++;
    if (!ok || pk_mag !== 32'd1500 || pk_idx !== 12'd15) begin
      errors++;
      $display("FAIL dc_skip_peak got ok=%0d mag=%0h idx=%0d exp 1 5dc 15", ok, pk_mag, pk_idx);
    end
    checks++;
    if (addr_log.size() != 16 || data_log[0] !== 10'd1023 || data_log[1] !== 10'd1023) begin
      errors++;
      $display("FAIL dc_skip_data got n=%0d d0=%0d d1=%0d exp 16 1023 1023",
               addr_log.size(), data_log[0], data_log[1]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_junk();
    test_scale();
    test_sof_mid();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
